// File: rtl/pb_intc_if.sv
// PicoBlaze port bus as seen by a pb_* peripheral: address, write data, strobes and read data.
interface pb_intc_if;
    logic [7:0] port_id;
    logic [7:0] data_in;
    logic       read_strobe;
    logic       write_strobe;
    logic [7:0] data_out;

    modport master (
        output port_id,
        output data_in,
        output read_strobe,
        output write_strobe,
        input  data_out
    );

    modport slave (
        input  port_id,
        input  data_in,
        input  read_strobe,
        input  write_strobe,
        output data_out
    );
endinterface

// File: rtl/pb_intc.sv
// PicoBlaze interrupt controller: masked, level/edge, polarity-selectable sources with a vector register.
// Define PB_INTC_SYNC_EN to pass irq_in through a 2-flop synchroniser.
module pb_intc #(
    parameter logic [7:0] BASE_ADDRESS = 8'h80,
    parameter int         NUM_IRQ      = 8
) (
    input  logic               clk,
    input  logic               reset,
    pb_intc_if.slave           bus,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               interrupt,
    input  logic               interrupt_ack
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_mode;
    logic [NUM_IRQ-1:0] r_polarity;
    logic [NUM_IRQ-1:0] r_hist;
    logic [1:0]         r_state;
    logic               r_interrupt;
    logic [7:0]         r_dout;

    logic [NUM_IRQ-1:0] w_src;
    logic [NUM_IRQ-1:0] w_act;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_active;
    logic [2:0]         w_off;
    logic [2:0]         w_idx;
    logic [7:0]         w_rdata;
    logic [1:0]         w_next;
    logic               w_sel;
    logic               w_wr;
    logic               w_eoi;
    logic               w_req;
    logic               w_unused;

`ifdef PB_INTC_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = irq_in;
`endif

    assign w_act    = w_src ^ r_polarity;
    assign w_rise   = w_act & ~r_hist;
    assign w_sel    = (bus.port_id[7:3] == BASE_ADDRESS[7:3]);
    assign w_off    = bus.port_id[2:0];
    assign w_wr     = w_sel & bus.write_strobe;
    assign w_w1c    = (w_wr && (w_off == 3'd0)) ? bus.data_in[NUM_IRQ-1:0] : '0;
    assign w_eoi    = w_wr && (w_off == 3'd5);
    assign w_active = r_pending & r_mask;
    assign w_req    = |w_active;
    assign w_unused = &{1'b0, bus.read_strobe, bus.data_in};

    // Scan downwards so the lowest-numbered active source is the one left in w_idx.
    always_comb begin
        w_idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            3'd0:    w_rdata = 8'(r_pending);
            3'd1:    w_rdata = 8'(r_mask);
            3'd2:    w_rdata = 8'(r_mode);
            3'd3:    w_rdata = 8'(r_polarity);
            3'd4:    w_rdata = w_req ? {1'b1, 4'b0000, w_idx} : 8'h00;
            default: w_rdata = 8'h00;
        endcase
    end

    // Edge bits: a fresh edge beats a simultaneous W1C; level bits track act each cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending  <= '0;
            r_mask     <= '0;
            r_mode     <= '0;
            r_polarity <= '0;
            r_hist     <= '0;
            r_dout     <= 8'h00;
        end else begin
            r_hist    <= w_act;
            r_pending <= (r_mode & (w_rise | (r_pending & ~w_w1c))) | (~r_mode & w_act);
            if (w_wr) begin
                case (w_off)
                    3'd1:    r_mask     <= bus.data_in[NUM_IRQ-1:0];
                    3'd2:    r_mode     <= bus.data_in[NUM_IRQ-1:0];
                    3'd3:    r_polarity <= bus.data_in[NUM_IRQ-1:0];
                    default: ;
                endcase
            end
            r_dout <= w_sel ? w_rdata : 8'h00;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_req) w_next = S_REQ;
            S_REQ: begin
                if (interrupt_ack) begin
                    w_next = S_SERVICE;
                end else if (!w_req) begin
                    w_next = S_IDLE;
                end
            end
            S_SERVICE: if (w_eoi) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_interrupt <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_interrupt <= (w_next == S_REQ);
        end
    end

    assign interrupt    = r_interrupt;
    assign bus.data_out = r_dout;

endmodule

// File: tb/tb_pb_intc.sv
// Directed testbench for pb_intc; expected values are hand-computed per scenario.
module tb_pb_intc;

`ifdef PB_INTC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam logic [7:0] BASE = 8'h80;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irqIn;
    logic       interrupt;
    logic       interruptAck;
    int         checkCount = 0;
    int         errorCount = 0;

    pb_intc_if bus ();

    pb_intc #(
        .BASE_ADDRESS (BASE),
        .NUM_IRQ      (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .irq_in        (irqIn),
        .interrupt     (interrupt),
        .interrupt_ack (interruptAck)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %02h expected %02h", tag, observed, expected);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic busWrite(input logic [2:0] off, input logic [7:0] data);
        bus.port_id      = BASE + 8'(off);
        bus.data_in      = data;
        bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.write_strobe = 1'b0;
        bus.port_id      = 8'h00;
    endtask

    task automatic readCheck(input string tag, input logic [2:0] off, input logic [7:0] expected);
        bus.port_id = BASE + 8'(off);
        @(negedge clk);
        checkOutput(tag, bus.data_out, expected);
        bus.port_id = 8'h00;
    endtask

    task automatic checkIrq(input string tag, input logic expected);
        checkOutput(tag, {7'b0, interrupt}, {7'b0, expected});
    endtask

    initial begin
        logic [7:0] outsideIds [4];
        outsideIds = '{8'h88, 8'h7F, 8'hF8, 8'h00};

        reset            = 1'b0;
        irqIn            = 8'h00;
        interruptAck     = 1'b0;
        bus.port_id      = 8'h00;
        bus.data_in      = 8'h00;
        bus.read_strobe  = 1'b0;
        bus.write_strobe = 1'b0;

        repeat (3) @(negedge clk);
        checkIrq("por_irq", 1'b0);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            readCheck($sformatf("por_reg%0d", i), 3'(i), 8'h00);
        end

        // Level source on bit 2
        busWrite(3'd1, 8'h04);
        busWrite(3'd2, 8'h00);
        readCheck("lvl_mask", 3'd1, 8'h04);
        irqIn = 8'h04;
        repeat (LAT) @(negedge clk);
        checkIrq("lvl_early", 1'b0);
        @(negedge clk);
        checkIrq("lvl_rise", 1'b1);
        readCheck("lvl_vector", 3'd4, 8'h82);
        busWrite(3'd0, 8'h04);
        readCheck("lvl_w1c_ignored", 3'd0, 8'h04);
        interruptAck = 1'b1;
        @(negedge clk);
        interruptAck = 1'b0;
        checkIrq("lvl_ack_fall", 1'b0);
        busWrite(3'd5, 8'hA5);
        checkIrq("lvl_eoi_edge", 1'b0);
        @(negedge clk);
        checkIrq("lvl_eoi_rerise", 1'b1);
        irqIn = 8'h00;
        busWrite(3'd1, 8'h00);
        repeat (LAT + 3) @(negedge clk);
        checkIrq("lvl_idle", 1'b0);

        // Edge source on bit 0 with W1C
        busWrite(3'd2, 8'h01);
        busWrite(3'd1, 8'h01);
        irqIn = 8'h01;
        repeat (2) @(negedge clk);
        irqIn = 8'h00;
        repeat (LAT + 3) @(negedge clk);
        readCheck("edge_pending", 3'd0, 8'h01);
        checkIrq("edge_irq", 1'b1);
        busWrite(3'd0, 8'h01);
        readCheck("edge_cleared", 3'd0, 8'h00);
        readCheck("edge_vector0", 3'd4, 8'h00);
        @(negedge clk);
        checkIrq("edge_idle", 1'b0);

        // Priority and polarity: park bit 5 high before making it active-low
        busWrite(3'd1, 8'h00);
        busWrite(3'd2, 8'h00);
        irqIn = 8'h20;
        repeat (LAT + 2) @(negedge clk);
        busWrite(3'd3, 8'h20);
        repeat (LAT + 2) @(negedge clk);
        busWrite(3'd2, 8'hFF);
        busWrite(3'd1, 8'hFF);
        readCheck("pri_quiet", 3'd0, 8'h00);
        checkIrq("pri_quiet_irq", 1'b0);
        irqIn = 8'h08;
        repeat (LAT + 3) @(negedge clk);
        readCheck("pri_pending", 3'd0, 8'h28);
        readCheck("pri_vector3", 3'd4, 8'h83);
        checkIrq("pri_irq", 1'b1);
        busWrite(3'd0, 8'h08);
        readCheck("pri_vector5", 3'd4, 8'h85);

        // A new edge and a W1C on bit 1 land on the same clock edge
        irqIn = 8'h0A;
        repeat (LAT - 1) @(negedge clk);
        busWrite(3'd0, 8'h02);
        readCheck("coll_set_wins", 3'd0, 8'h22);
        busWrite(3'd0, 8'h02);
        readCheck("coll_plain_clear", 3'd0, 8'h20);

        // Masking the only request while in REQ
        checkIrq("drop_pre", 1'b1);
        busWrite(3'd1, 8'h00);
        @(negedge clk);
        checkIrq("drop_idle", 1'b0);

        // Bus isolation while PENDING is non-zero
        busWrite(3'd1, 8'hFF);
        readCheck("iso_pending", 3'd0, 8'h20);
        for (int i = 0; i < 4; i++) begin
            bus.port_id = outsideIds[i];
            @(negedge clk);
            checkOutput($sformatf("iso_id%02h", outsideIds[i]), bus.data_out, 8'h00);
        end

        // Reset asserted while in REQ with addressed read data present
        repeat (2) @(negedge clk);
        checkIrq("mid_pre_irq", 1'b1);
        bus.port_id = BASE;
        @(negedge clk);
        checkOutput("mid_pre_dout", bus.data_out, 8'h20);
        reset = 1'b0;
        #1;
        checkIrq("mid_rst_irq", 1'b0);
        checkOutput("mid_rst_dout", bus.data_out, 8'h00);
        bus.port_id = 8'h00;
        irqIn       = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            readCheck($sformatf("mid_reg%0d", i), 3'(i), 8'h00);
        end
        checkIrq("mid_final_irq", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pb_intc.md
# pb_intc

Parametrised PicoBlaze interrupt controller that replaces the fixed OR of peripheral interrupt lines feeding the CPU `interrupt` input. It collects up to eight interrupt sources and gives each one a mask bit, a level/edge mode and a polarity. It latches pending requests, drives a single `interrupt` request held until the CPU acknowledges it, and reports the highest-priority source through a vector register. It sits on the `port_id`/`out_port`/`in_port` bus like every other `pb_*` peripheral; its `data_out` is ORed into `in_port`.

## Interface
- `BASE_ADDRESS`, 8'h80: base port; the block decodes `port_id[7:3] == BASE_ADDRESS[7:3]` (8 ports).
- `NUM_IRQ`, 8: number of sources, legal range 1..8.

Ports:
- `clk` input 1: system clock (`clk_sys`); the block has one clock.
- `reset` input 1: asynchronous, active-low reset.
- `port_id` input 8: CPU port address.
- `data_in` input 8: CPU write data (`out_port`).
- `read_strobe` input 1: CPU read strobe; unused, because reads have no side effects.
- `write_strobe` input 1: CPU write strobe.
- `data_out` output 8: registered read data; 8'h00 when the block is not addressed.
- `irq_in` input NUM_IRQ: raw interrupt sources, which may be asynchronous (e.g. `int1`, `int2`).
- `interrupt` output 1: request to the CPU.
- `interrupt_ack` input 1: one-cycle acknowledge from the CPU.

## Operation
- Register offsets, taken from `port_id[2:0]`; bits at or above NUM_IRQ read 0 and ignore writes:
  - 0 PENDING: R/W1C.
  - 1 MASK: R/W, 1 = enabled.
  - 2 MODE: R/W, 1 = edge, 0 = level.
  - 3 POLARITY: R/W, 1 = active-low.
  - 4 VECTOR: RO, `{valid, 4'b0, idx[2:0]}`.
  - 5 EOI: write-only; reads return 0.
  - 6 and 7: read 0; writes are ignored.
- Source conditioning: `act[i] = sync(irq_in[i]) ^ POLARITY[i]`.
- Level mode: `PENDING[i]` follows `act[i]` every cycle, and W1C has no effect.
- Edge mode: a rising edge of `act[i]` sets `PENDING[i]`, and W1C clears it. If a set and a clear hit the same cycle, the set wins.
- `req = |(PENDING & MASK)`.
- VECTOR:
  - `idx` is the lowest-numbered bit set in `PENDING & MASK`; the lowest index has the highest priority.
  - `valid = req`.
  - If `req` is 0, VECTOR reads 8'h00.
- Request FSM, with `interrupt` registered and equal to (state == REQ):
  - IDLE → REQ when `req` is 1.
  - REQ → SERVICE on `interrupt_ack`.
  - REQ → IDLE if `req` drops before the acknowledge (source masked or cleared).
  - SERVICE → IDLE on a write to EOI. The write data is ignored.
  - EOI writes in IDLE or REQ are ignored.
  - `interrupt_ack` in IDLE or SERVICE is ignored.
- Changing MODE from edge to level on a bit reloads that `PENDING` bit from `act` on the next cycle. Changing from level to edge keeps the current value.
- Reset, including reset asserted mid-operation, immediately forces:
  - PENDING, MASK, MODE and POLARITY to 0;
  - the FSM to IDLE;
  - `interrupt` to 0 and `data_out` to 8'h00;
  - the synchroniser and edge-history flops to 0.

## Timing
- Register writes take effect at the clock edge where `write_strobe` is high and the block is addressed.
- `data_out` is registered, with one cycle of latency from `port_id`.
- `data_out` returns 8'h00 on the clock after `port_id` leaves the block's range.
- The controller adds no wait states; the PicoBlaze two-cycle port read meets this timing.
- With the synchroniser, latency from the first clock edge that samples `irq_in` active to `interrupt` high is 3 edges: sync1, sync2, then pending/history, with the FSM register giving the last edge.
- Without the synchroniser, the same latency is 1 edge for edge mode and 1 edge for level mode.
- `interrupt` falls on the edge that samples `interrupt_ack`.
- After an EOI write, `interrupt` rises again one edge later if `req` is still set.
- Edge mode needs `act` low for at least one sampled cycle between edges. A pulse shorter than one clock period may be missed.

## Configuration
- `PB_INTC_SYNC_EN`
  - Defined: each `irq_in` bit passes through a 2-flop synchroniser, and edge detection compares the synchroniser output with a history flop.
  - Undefined: `irq_in` is used directly. It must already be synchronous to `clk`; latencies are as listed under Timing.

## Test plan
- Power-up and reset:
  - Hold `reset`=0 for 3 cycles, then read offsets 0–7 → every read returns 8'h00, and `interrupt`=0.
  - Start an interrupt cycle, then assert `reset`=0 while in REQ → `interrupt` drops to 0 immediately and all registers read 0.
- Level source:
  - Set MASK=8'h04, MODE=0.
  - Raise `irq_in[2]` → `interrupt`=1 after 3 clocks; VECTOR=8'h82.
  - Pulse `interrupt_ack` → `interrupt`=0.
  - Write EOI with `irq_in[2]` still high → `interrupt`=1 again one edge later.
- Edge source and W1C:
  - Set MODE=8'h01, MASK=8'h01.
  - Pulse `irq_in[0]` high for 2 cycles → PENDING=8'h01, which persists after the input falls.
  - Write 8'h01 to offset 0 → PENDING=8'h00 and VECTOR=8'h00.
- Priority and polarity:
  - Set MASK=8'hFF, MODE=8'hFF, POLARITY=8'h20.
  - Drive `irq_in` falling edge on bit 5 and rising edge on bit 3 in the same cycle → PENDING=8'h28, VECTOR=8'h83.
  - Clear bit 3 → VECTOR=8'h85.
- Set/clear collision and masked drop:
  - Write W1C for bit 1 on the same edge that a new edge sets bit 1 → PENDING[1] stays 1.
  - In REQ, write MASK=0 → FSM returns to IDLE and `interrupt`=0 with no acknowledge.
- Bus isolation: `port_id` outside BASE_ADDRESS..BASE_ADDRESS+7 while PENDING≠0 → `data_out`=8'h00 on every cycle.
